reg_scoreboard: RTL and testbench

Register-file scoreboard and issue-stall controller for the pipelined MIPS datapath. Tracks which of the 31 writable registers have an in-flight write, using the nonzero register-number equality semantics (register 0 never matches and is never pending). Decides each cycle whether the instruction in decode may issue. Sits between the decode stage and the issue/EX pipeline register and counts stall cycles for performance reporting.

---
 rtl/reg_scoreboard_if.sv | 40 ++++
 rtl/reg_scoreboard.sv | 86 ++++++++
 tb/tb_reg_scoreboard.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback handshake bundle for the register scoreboard.
// master: decode + writeback side; slave: scoreboard.
interface reg_scoreboard_if #(
  parameter int CNT_W = 16
);
  logic             issue_valid;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             rs_used;
  logic             rt_used;
  logic [4:0]       rd;
  logic             rd_write;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             stall;
  logic             issue_fire;
  logic [31:0]      busy;
  logic [5:0]       pending_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output issue_valid, rs, rt,
    output rs_used, rt_used,
    output rd, rd_write,
    output wb_valid, wb_rd,
    input  stall, issue_fire,
    input  busy, pending_count,
    input  stall_count
  );

  modport slave (
    input  issue_valid, rs, rt,
    input  rs_used, rt_used,
    input  rd, rd_write,
    input  wb_valid, wb_rd,
    output stall, issue_fire,
    output busy, pending_count,
    output stall_count
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard and issue-stall control for decode.
// Ports: clk, reset (async high), sb (slave bundle):
//   decode request in, writeback in, stall/fire/busy/counts out.
module reg_scoreboard #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  reg_scoreboard_if.slave sb
);

  logic [31:0]      busy_q;
  logic [31:0]      busy_d;
  logic [31:0]      wb_dec;
  logic [31:0]      set_dec;
  logic [31:0]      eff;
  logic [5:0]       pend_q;
  logic [5:0]       pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic             raw;
  logic             waw;
  logic             stall;
  logic             fire;

  // One-hot writeback; register 0 never matches.
  always_comb begin
    wb_dec = '0;
    if (sb.wb_valid) begin
      wb_dec[sb.wb_rd] = 1'b1;
    end
    wb_dec[0] = 1'b0;
  end

  // Same-cycle writeback hides the hazard (write-then-read RF).
  assign eff = busy_q & ~wb_dec;

  assign raw = (sb.rs_used & eff[sb.rs])
             | (sb.rt_used & eff[sb.rt]);
  assign waw = sb.rd_write & eff[sb.rd];

  assign stall = sb.issue_valid & (raw | waw);
  assign fire  = sb.issue_valid & ~stall;

  always_comb begin
    set_dec = '0;
    if (fire && sb.rd_write) begin
      set_dec[sb.rd] = 1'b1;
    end
    set_dec[0] = 1'b0;
  end

  // Set wins over clear for the same register.
  assign busy_d = (busy_q & ~wb_dec) | set_dec;

  always_comb begin
    pend_d = '0;
    for (int i = 1; i < 32; i++) begin
      pend_d = pend_d + 6'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sb.stall         = stall;
  assign sb.issue_fire    = fire;
  assign sb.busy          = busy_q;
  assign sb.pending_count = pend_q;
  assign sb.stall_count   = cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard (CNT_W=4).
// Array-based pending model, directed pins, random run.
module tb_reg_scoreboard;

  localparam int CW = 4;

  logic clk;
  logic reset;

  reg_scoreboard_if #(.CNT_W(CW)) sb ();

  reg_scoreboard #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit pend [32];
  int m_scnt;
  bit prev_stall;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) pend[r] = 1'b0;
    m_scnt = 0;
    prev_stall = 1'b0;
  endtask

  function automatic bit m_eff(logic [4:0] r);
    if (r == 0) return 1'b0;
    if (sb.wb_valid && sb.wb_rd == r) return 1'b0;
    return pend[r];
  endfunction

  // Compare DUT against the model, then advance the model
  // with the inputs that will be sampled at the next edge.
  task automatic cycle();
    bit          e_stall;
    bit          e_fire;
    logic [31:0] e_busy;
    int          e_cnt;
    @(negedge clk);
    e_stall = sb.issue_valid &&
              ((sb.rs_used && m_eff(sb.rs)) ||
               (sb.rt_used && m_eff(sb.rt)) ||
               (sb.rd_write && m_eff(sb.rd)));
    e_fire = sb.issue_valid && !e_stall;
    e_busy = '0;
    e_cnt = 0;
    for (int r = 1; r < 32; r++) begin
      e_busy[r] = pend[r];
      e_cnt += int'(pend[r]);
    end
    chk("stall", 64'(sb.stall), 64'(e_stall));
    chk("issue_fire", 64'(sb.issue_fire), 64'(e_fire));
    chk("busy", 64'(sb.busy), 64'(e_busy));
    chk("pending_count", 64'(sb.pending_count), 64'(e_cnt));
    chk("stall_count", 64'(sb.stall_count), 64'(m_scnt));
    for (int r = 1; r < 32; r++) begin
      if (e_fire && sb.rd_write && sb.rd == r)
        pend[r] = 1'b1;
      else if (sb.wb_valid && sb.wb_rd == r)
        pend[r] = 1'b0;
    end
    if (e_stall && m_scnt < (1 << CW) - 1) m_scnt++;
    prev_stall = e_stall;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    sb.issue_valid = 0;
    sb.rs = 0; sb.rt = 0; sb.rd = 0;
    sb.rs_used = 0; sb.rt_used = 0; sb.rd_write = 0;
    sb.wb_valid = 0; sb.wb_rd = 0;
  endtask

  task automatic dec(logic [4:0] rs_i, bit rsu,
                     logic [4:0] rt_i, bit rtu,
                     logic [4:0] rd_i, bit rdw);
    sb.issue_valid = 1;
    sb.rs = rs_i; sb.rs_used = rsu;
    sb.rt = rt_i; sb.rt_used = rtu;
    sb.rd = rd_i; sb.rd_write = rdw;
  endtask

  initial begin
    idle_in();
    model_clear();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(sb.busy), 64'h0);
    chk("rst_pend", 64'(sb.pending_count), 64'h0);
    chk("rst_scnt", 64'(sb.stall_count), 64'h0);
    chk("rst_stall", 64'(sb.stall), 64'h0);
    chk("rst_fire", 64'(sb.issue_fire), 64'h0);
    reset = 1'b0;
    cycle();

    // Producer rd=8
    dec(0, 0, 0, 0, 8, 1);
    #1 chk("p8_fire", 64'(sb.issue_fire), 64'h1);
    cycle();
    chk("p8_busy", 64'(sb.busy), 64'h100);
    chk("p8_pend", 64'(sb.pending_count), 64'h1);

    // Dependent stalls 3 cycles, then issues on wb
    dec(8, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_stall", 64'(sb.stall), 64'h1);
      cycle();
    end
    chk("raw_scnt", 64'(sb.stall_count), 64'h3);
    sb.wb_valid = 1; sb.wb_rd = 8;
    #1;
    chk("wb_stall", 64'(sb.stall), 64'h0);
    chk("wb_fire", 64'(sb.issue_fire), 64'h1);
    cycle();
    chk("wb_busy", 64'(sb.busy), 64'h0);
    sb.wb_valid = 0;

    // Register 0 never pending
    dec(0, 0, 0, 0, 0, 1);
    #1 chk("r0_fire", 64'(sb.issue_fire), 64'h1);
    cycle();
    dec(0, 1, 0, 0, 0, 0);
    #1 chk("r0_stall", 64'(sb.stall), 64'h0);
    cycle();
    chk("r0_busy", 64'(sb.busy), 64'h0);

    // Set wins over clear on reg 5
    dec(0, 0, 0, 0, 5, 1);
    cycle();
    sb.wb_valid = 1; sb.wb_rd = 5;
    #1 chk("sw_fire", 64'(sb.issue_fire), 64'h1);
    cycle();
    chk("sw_busy", 64'(sb.busy), 64'h20);
    idle_in();
    sb.wb_valid = 1; sb.wb_rd = 5;
    cycle();
    sb.wb_valid = 0;

    // Unused rt ignores hazard; WAW stalls
    dec(0, 0, 0, 0, 9, 1);
    cycle();
    dec(0, 0, 9, 0, 10, 1);
    #1 chk("rt_unused", 64'(sb.stall), 64'h0);
    cycle();
    dec(0, 0, 0, 0, 9, 1);
    #1 chk("waw_stall", 64'(sb.stall), 64'h1);
    cycle();

    // Saturation: 20 more stalls on reg 9
    dec(9, 1, 0, 0, 0, 0);
    repeat (20) cycle();
    chk("sat_scnt", 64'(sb.stall_count), 64'hF);

    // Async reset mid-cycle while stalling
    #2;
    reset = 1'b1;
    sb.issue_valid = 0;
    #1;
    chk("ar_busy", 64'(sb.busy), 64'h0);
    chk("ar_pend", 64'(sb.pending_count), 64'h0);
    chk("ar_scnt", 64'(sb.stall_count), 64'h0);
    chk("ar_stall", 64'(sb.stall), 64'h0);
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
    idle_in();
    sb.wb_valid = 1; sb.wb_rd = 9;
    cycle();
    chk("late_wb", 64'(sb.busy), 64'h0);

    // Random run; stalled instruction held stable
    for (int n = 0; n < 800; n++) begin
      if (!prev_stall || !sb.issue_valid) begin
        sb.issue_valid = ($urandom_range(0, 3) != 0);
        sb.rs = 5'($urandom_range(0, 7));
        sb.rt = 5'($urandom_range(0, 7));
        sb.rd = 5'($urandom_range(0, 7));
        sb.rs_used = 1'($urandom_range(0, 1));
        sb.rt_used = 1'($urandom_range(0, 1));
        sb.rd_write = ($urandom_range(0, 3) != 0);
      end
      sb.wb_valid = ($urandom_range(0, 2) == 0);
      sb.wb_rd = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
